// File: rtl/event_hub.sv
// ---------------------------------------------------------------------------
// event_hub
//
// Purpose
//   Event front end for the board's pad and button inputs. There are N_EVT raw
//   inputs. Each one is synchronised, then debounced on an internal divided
//   tick. The block publishes three things:
//     - a per-channel toggle bit,
//     - a one-cycle press pulse,
//     - an ordered first-word-fall-through FIFO of press codes.
//   Downstream LED, RGB and 7-segment handlers pop the FIFO.
//
// Ports
//   CLK         in   1          system clock
//   RST         in   1          asynchronous, active-high reset
//   evt_in      in   N_EVT      raw asynchronous pad inputs, 1 = pressed
//   tick        out  1          1-cycle strobe every DIV cycles
//   evt_toggle  out  N_EVT      per-channel toggle, flips on each debounced press
//   evt_pulse   out  N_EVT      1-cycle strobe on each debounced press
//   q_valid     out  1          FIFO non-empty; q_code/q_hold are valid
//   q_ready     in   1          head is consumed when q_valid && q_ready
//   q_code      out  IW         channel index of the head entry
//   q_hold      out  1          head entry is a long-press
//   q_count     out  CW         number of entries held
//   overflow    out  1          sticky: an event was lost
//   clr_ovf     in   1          synchronous clear of overflow (wins over a set)
//
// Handshake
//   q_valid/q_ready follow plain valid/ready rules. An entry is popped on a
//   cycle where both are high. q_ready while empty has no effect. The head is
//   visible combinationally from the stored entry.
//
// Configuration
//   EVENT_HUB_HOLD_EN : when defined, a per-channel hold counter is added. It
//   queues one extra entry with q_hold=1 after HOLD_TICKS ticks of continuous
//   press. When undefined, q_hold is tied to 0. The FIFO entry keeps its
//   IW+1 width in both builds.
// ---------------------------------------------------------------------------
module event_hub #(
    parameter int N_EVT      = 12,
    parameter int DIV        = 20000,
    parameter int DB_TICKS   = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int HOLD_TICKS = 500,
    localparam int IW        = $clog2(N_EVT),
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_EVT-1:0] evt_in,
    output logic             tick,
    output logic [N_EVT-1:0] evt_toggle,
    output logic [N_EVT-1:0] evt_pulse,
    output logic             q_valid,
    input  logic             q_ready,
    output logic [IW-1:0]    q_code,
    output logic             q_hold,
    output logic [CW-1:0]    q_count,
    output logic             overflow,
    input  logic             clr_ovf
);

    localparam int DW = $clog2(DIV);
    localparam int AW = CW - 1;

    // -----------------------------------------------------------------------
    // Tick divider
    // -----------------------------------------------------------------------
    logic [DW-1:0] div_q, div_d;

    assign tick = (div_q == DW'(DIV - 1));

    always_comb begin
        div_d = div_q + DW'(1);
        if (tick) begin
            div_d = '0;
        end
    end

    // -----------------------------------------------------------------------
    // Synchroniser and debouncer
    // -----------------------------------------------------------------------
    logic [N_EVT-1:0] sync1_q, sync2_q;
    logic [N_EVT-1:0] stable_q, stable_d;
    logic [3:0]       dbc_q [N_EVT];
    logic [3:0]       dbc_d [N_EVT];
    logic [N_EVT-1:0] press;

    // The counter only moves on tick.
    // It counts consecutive ticks on which the synchronised level differs from
    // the accepted level. It is cleared as soon as the two agree again.
    // The new level is accepted on the tick that would bring the count to
    // DB_TICKS.
    always_comb begin
        stable_d = stable_q;
        press    = '0;
        for (int i = 0; i < N_EVT; i++) begin
            dbc_d[i] = dbc_q[i];
            if (tick) begin
                if (sync2_q[i] != stable_q[i]) begin
                    if (dbc_q[i] == 4'(DB_TICKS - 1)) begin
                        stable_d[i] = sync2_q[i];
                        dbc_d[i]    = '0;
                        press[i]    = sync2_q[i];
                    end else begin
                        dbc_d[i] = dbc_q[i] + 4'd1;
                    end
                end else begin
                    dbc_d[i] = '0;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Press outputs
    // -----------------------------------------------------------------------
    logic [N_EVT-1:0] pulse_q, toggle_q;
    logic [N_EVT-1:0] pend_q, pend_d;
    logic             ovf_q, ovf_d;

    assign evt_pulse  = pulse_q;
    assign evt_toggle = toggle_q;
    assign overflow   = ovf_q;

    // -----------------------------------------------------------------------
    // FIFO state
    // -----------------------------------------------------------------------
    logic [IW:0]   mem_q [FIFO_DEPTH];
    logic [CW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count;
    logic          full;
    logic          push, pop;
    logic [IW:0]   wr_data;
    logic [IW:0]   head;

    assign count   = wr_q - rd_q;
    assign full    = (count == CW'(FIFO_DEPTH));
    assign q_valid = (count != '0);
    assign q_count = count;
    assign pop     = q_valid && q_ready;
    assign head    = mem_q[rd_q[AW-1:0]];

    // Gating keeps the outputs at 0 while empty, including right after a
    // reset that leaves stale words in the storage array.
    assign q_code = q_valid ? head[IW-1:0] : '0;

    // -----------------------------------------------------------------------
    // Short-press arbitration: lowest pending index wins
    // -----------------------------------------------------------------------
    logic             short_any;
    logic [IW-1:0]    short_sel;
    logic [N_EVT-1:0] short_grant;
    logic [N_EVT-1:0] short_lost;

    always_comb begin
        short_sel = '0;
        for (int i = N_EVT - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                short_sel = IW'(i);
            end
        end
    end

    assign short_any   = |pend_q;
    assign short_grant = (push && short_any) ? (N_EVT'(1) << short_sel) : '0;
    // A pending bit that is being drained this very cycle can take a new
    // press without loss.
    assign short_lost  = press & pend_q & ~short_grant;

    always_comb begin
        pend_d = (pend_q & ~short_grant) | press;
    end

`ifdef EVENT_HUB_HOLD_EN
    // -----------------------------------------------------------------------
    // Long-press detection
    // -----------------------------------------------------------------------
    localparam int HW = $clog2(HOLD_TICKS + 1);

    logic [HW-1:0]    hcnt_q [N_EVT];
    logic [HW-1:0]    hcnt_d [N_EVT];
    logic [N_EVT-1:0] hold_fire;
    logic [N_EVT-1:0] hpend_q, hpend_d;
    logic             hold_any;
    logic [IW-1:0]    hold_sel;
    logic [N_EVT-1:0] hold_grant;
    logic [N_EVT-1:0] hold_lost;

    // The counter saturates at HOLD_TICKS, so it fires only once per press.
    // Release clears it, ready for the next press.
    always_comb begin
        hold_fire = '0;
        for (int i = 0; i < N_EVT; i++) begin
            hcnt_d[i] = hcnt_q[i];
            if (!stable_q[i]) begin
                hcnt_d[i] = '0;
            end else if (tick && (hcnt_q[i] != HW'(HOLD_TICKS))) begin
                hcnt_d[i] = hcnt_q[i] + HW'(1);
                if (hcnt_q[i] == HW'(HOLD_TICKS - 1)) begin
                    hold_fire[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        hold_sel = '0;
        for (int i = N_EVT - 1; i >= 0; i--) begin
            if (hpend_q[i]) begin
                hold_sel = IW'(i);
            end
        end
    end

    assign hold_any   = |hpend_q;
    // Short presses always go ahead of long-press entries.
    assign hold_grant = (push && !short_any && hold_any) ? (N_EVT'(1) << hold_sel) : '0;
    assign hold_lost  = hold_fire & hpend_q & ~hold_grant;

    always_comb begin
        hpend_d = (hpend_q & ~hold_grant) | hold_fire;
    end

    assign push    = (short_any || hold_any) && !full;
    assign wr_data = short_any ? {1'b0, short_sel} : {1'b1, hold_sel};
    assign q_hold  = q_valid && head[IW];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hpend_q <= '0;
            for (int i = 0; i < N_EVT; i++) begin
                hcnt_q[i] <= '0;
            end
        end else begin
            hpend_q <= hpend_d;
            for (int i = 0; i < N_EVT; i++) begin
                hcnt_q[i] <= hcnt_d[i];
            end
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end else if ((|short_lost) || (|hold_lost)) begin
            ovf_d = 1'b1;
        end
    end
`else
    // Without long-press support the stored hold bit is always written as 0,
    // and q_hold is tied off.
    logic unused_cfg;

    assign push       = short_any && !full;
    assign wr_data    = {1'b0, short_sel};
    assign q_hold     = 1'b0;
    assign unused_cfg = head[IW] ^ (HOLD_TICKS != 0);

    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end else if (|short_lost) begin
            ovf_d = 1'b1;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // FIFO pointers
    // -----------------------------------------------------------------------
    // Full is taken from the registered count. A pop in the same cycle
    // therefore does not make room for a push until the next cycle.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push) begin
            wr_d = wr_q + CW'(1);
        end
        if (pop) begin
            rd_d = rd_q + CW'(1);
        end
    end

    // Storage is not reset: the pointers alone define which words are live.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]] <= wr_data;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_q    <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            pulse_q  <= '0;
            toggle_q <= '0;
            pend_q   <= '0;
            ovf_q    <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
            for (int i = 0; i < N_EVT; i++) begin
                dbc_q[i] <= '0;
            end
        end else begin
            div_q    <= div_d;
            sync1_q  <= evt_in;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            pulse_q  <= press;
            toggle_q <= toggle_q ^ press;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            for (int i = 0; i < N_EVT; i++) begin
                dbc_q[i] <= dbc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_event_hub.sv
module tb_event_hub;

    localparam int N_EVT      = 12;
    localparam int DIV        = 4;
    localparam int DB_TICKS   = 2;
    localparam int FIFO_DEPTH = 8;
`ifdef EVENT_HUB_HOLD_EN
    // Long enough that channels held through the table never reach a hold.
    localparam int HOLD_T     = 150;
`else
    localparam int HOLD_T     = 10;
`endif
    localparam int IW         = $clog2(N_EVT);
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [N_EVT-1:0] evt_in = '0;
    logic             q_ready = 1'b0;
    logic             clr_ovf = 1'b0;
    logic             tick;
    logic [N_EVT-1:0] evt_toggle;
    logic [N_EVT-1:0] evt_pulse;
    logic             q_valid;
    logic [IW-1:0]    q_code;
    logic             q_hold;
    logic [CW-1:0]    q_count;
    logic             overflow;

    always #5 CLK = ~CLK;

    event_hub #(
        .N_EVT(N_EVT), .DIV(DIV), .DB_TICKS(DB_TICKS),
        .FIFO_DEPTH(FIFO_DEPTH), .HOLD_TICKS(HOLD_T)
    ) dut (
        .CLK(CLK), .RST(RST), .evt_in(evt_in), .tick(tick),
        .evt_toggle(evt_toggle), .evt_pulse(evt_pulse),
        .q_valid(q_valid), .q_ready(q_ready), .q_code(q_code),
        .q_hold(q_hold), .q_count(q_count), .overflow(overflow),
        .clr_ovf(clr_ovf)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_bad = 0;
    int pulse_total = 0;
    logic [IW-1:0] exp_q[$];

    always @(negedge CLK) begin
        pulse_total += $countones(evt_pulse);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_ticks(input int n);
        repeat (n * DIV) @(negedge CLK);
    endtask

    task automatic pop_one();
        q_ready = 1'b1;
        @(negedge CLK);
        q_ready = 1'b0;
    endtask

    task automatic align_tick();
        for (int c = 0; c < 2 * DIV; c++) begin
            @(negedge CLK);
            if (tick) return;
        end
        check("align_tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain_expected(input string name);
        while (exp_q.size() != 0) begin
            check({name, "_code"}, 32'(q_code), 32'(exp_q.pop_front()));
            check({name, "_hold"}, 32'(q_hold), 32'd0);
            pop_one();
        end
        check({name, "_empty"}, 32'(q_valid), 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [N_EVT-1:0] evt;
        logic             rdy;
        logic             clr;
        logic [CW-1:0]    exp_count;
        logic [IW-1:0]    exp_code;
        logic [N_EVT-1:0] exp_toggle;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[13];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        int ticks_seen;
        int pulse_seen;
        logic prev_tick;
        logic found;

        // Fill order: ch0..ch7 into the FIFO, ch8 stays pending, then a lost re-press.
        vecs[0]  = '{12'h000, 1'b0, 1'b0, 4'd0, 4'd0, 12'h02C, 1'b0};
        vecs[1]  = '{12'h001, 1'b0, 1'b0, 4'd1, 4'd0, 12'h02D, 1'b0};
        vecs[2]  = '{12'h003, 1'b0, 1'b0, 4'd2, 4'd0, 12'h02F, 1'b0};
        vecs[3]  = '{12'h007, 1'b0, 1'b0, 4'd3, 4'd0, 12'h02B, 1'b0};
        vecs[4]  = '{12'h00F, 1'b0, 1'b0, 4'd4, 4'd0, 12'h023, 1'b0};
        vecs[5]  = '{12'h01F, 1'b0, 1'b0, 4'd5, 4'd0, 12'h033, 1'b0};
        vecs[6]  = '{12'h03F, 1'b0, 1'b0, 4'd6, 4'd0, 12'h013, 1'b0};
        vecs[7]  = '{12'h07F, 1'b0, 1'b0, 4'd7, 4'd0, 12'h053, 1'b0};
        vecs[8]  = '{12'h0FF, 1'b0, 1'b0, 4'd8, 4'd0, 12'h0D3, 1'b0};
        vecs[9]  = '{12'h1FF, 1'b0, 1'b0, 4'd8, 4'd0, 12'h1D3, 1'b0};
        vecs[10] = '{12'h0FF, 1'b0, 1'b0, 4'd8, 4'd0, 12'h1D3, 1'b0};
        vecs[11] = '{12'h1FF, 1'b0, 1'b0, 4'd8, 4'd0, 12'h0D3, 1'b1};
        vecs[12] = '{12'h1FF, 1'b0, 1'b1, 4'd8, 4'd0, 12'h0D3, 1'b0};

        // ---- reset state ----
        repeat (3) @(negedge CLK);
        check("rst_tick",     32'(tick),       32'd0);
        check("rst_toggle",   32'(evt_toggle), 32'd0);
        check("rst_pulse",    32'(evt_pulse),  32'd0);
        check("rst_valid",    32'(q_valid),    32'd0);
        check("rst_count",    32'(q_count),    32'd0);
        check("rst_code",     32'(q_code),     32'd0);
        check("rst_hold",     32'(q_hold),     32'd0);
        check("rst_overflow", 32'(overflow),   32'd0);
        RST = 1'b0;

        // ---- single press on ch3: latency relative to ticks ----
        align_tick();
        evt_in[3] = 1'b1;
        ticks_seen = 0;
        prev_tick  = 1'b0;
        found      = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (evt_pulse[3]) begin
                found = 1'b1;
                break;
            end
            ticks_seen += int'(tick);
            prev_tick = tick;
        end
        check("p3_found",      32'(found),      32'd1);
        check("p3_ticks",      32'(ticks_seen), 32'd2);
        check("p3_after_tick", 32'(prev_tick),  32'd1);
        check("p3_pulse_vec",  32'(evt_pulse),  32'h008);
        check("p3_toggle",     32'(evt_toggle), 32'h008);
        @(negedge CLK);
        check("p3_pulse_width", 32'(evt_pulse), 32'h000);
        check("p3_valid",       32'(q_valid),   32'd1);
        check("p3_code",        32'(q_code),    32'd3);
        check("p3_count",       32'(q_count),   32'd1);
        pop_one();
        check("p3_popped", 32'(q_count), 32'd0);

        // release produces no event
        evt_in[3] = 1'b0;
        wait_ticks(6);
        check("rel3_pulses", 32'(pulse_total), 32'd1);
        check("rel3_toggle", 32'(evt_toggle),  32'h008);
        check("rel3_valid",  32'(q_valid),     32'd0);

        // ---- glitch on ch0: high for exactly one tick period ----
        align_tick();
        evt_in[0] = 1'b1;
        repeat (DIV) @(negedge CLK);
        evt_in[0] = 1'b0;
        wait_ticks(6);
        check("glitch_pulses", 32'(pulse_total), 32'd1);
        check("glitch_valid",  32'(q_valid),     32'd0);
        check("glitch_toggle", 32'(evt_toggle),  32'h008);

        // ---- ch5 and ch2 rise together: drained lowest index first ----
        evt_in = 12'h024;
        wait_ticks(6);
        check("dual_count",  32'(q_count),    32'd2);
        check("dual_code0",  32'(q_code),     32'd2);
        check("dual_toggle", 32'(evt_toggle), 32'h02C);
        pop_one();
        check("dual_code1",  32'(q_code),  32'd5);
        check("dual_count1", 32'(q_count), 32'd1);
        pop_one();
        check("dual_empty",  32'(q_valid), 32'd0);

        // ---- table: fill to full, pending overflow, clear ----
        for (int v = 0; v < 13; v++) begin
            evt_in  = vecs[v].evt;
            q_ready = vecs[v].rdy;
            clr_ovf = vecs[v].clr;
            @(negedge CLK);
            clr_ovf = 1'b0;
            wait_ticks(8);
            check($sformatf("vec%0d_count", v),  32'(q_count),    32'(vecs[v].exp_count));
            check($sformatf("vec%0d_valid", v),  32'(q_valid),    32'(vecs[v].exp_count != 0));
            check($sformatf("vec%0d_code", v),   32'(q_code),     32'(vecs[v].exp_code));
            check($sformatf("vec%0d_toggle", v), 32'(evt_toggle), 32'(vecs[v].exp_toggle));
            check($sformatf("vec%0d_ovf", v),    32'(overflow),   32'(vecs[v].exp_ovf));
        end
        q_ready = 1'b0;

        // ---- pop two back to back: the first pop does not free a slot for
        //      ch8 in its own cycle; the second pop coincides with its push ----
        check("full_head", 32'(q_code), 32'd0);
        q_ready = 1'b1;
        repeat (2) @(negedge CLK);
        q_ready = 1'b0;
        check("pushpop_count", 32'(q_count), 32'd7);
        for (int k = 2; k <= 8; k++) exp_q.push_back(IW'(k));
        drain_expected("drain");
        check("drain_count", 32'(q_count), 32'd0);

        evt_in = '0;
        wait_ticks(6);
        check("release_toggle", 32'(evt_toggle), 32'h0D3);
        check("release_valid",  32'(q_valid),    32'd0);

        // ---- reset with three entries queued ----
        evt_in = 12'hE00;
        wait_ticks(8);
        check("pre_rst_count",  32'(q_count),    32'd3);
        check("pre_rst_code",   32'(q_code),     32'd9);
        check("pre_rst_hold",   32'(q_hold),     32'd0);
        check("pre_rst_toggle", 32'(evt_toggle), 32'hED3);
        #2 RST = 1'b1;
        #1;
        check("mid_rst_valid",  32'(q_valid),    32'd0);
        check("mid_rst_count",  32'(q_count),    32'd0);
        check("mid_rst_toggle", 32'(evt_toggle), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        wait_ticks(8);
        check("post_rst_count",  32'(q_count),    32'd3);
        check("post_rst_toggle", 32'(evt_toggle), 32'hE00);
        exp_q.push_back(IW'(9));
        exp_q.push_back(IW'(10));
        exp_q.push_back(IW'(11));
        drain_expected("post_rst");
        evt_in = '0;
        wait_ticks(6);

`ifdef EVENT_HUB_HOLD_EN
        // ---- long press on ch1: a short entry, then one hold entry ----
        evt_in = 12'h002;
        wait_ticks(HOLD_T + 10);
        check("hold_count", 32'(q_count), 32'd2);
        wait_ticks(10);
        check("hold_no_repeat", 32'(q_count), 32'd2);
        check("hold_e0_code", 32'(q_code), 32'd1);
        check("hold_e0_hold", 32'(q_hold), 32'd0);
        pop_one();
        check("hold_e1_code", 32'(q_code), 32'd1);
        check("hold_e1_hold", 32'(q_hold), 32'd1);
        pop_one();
        check("hold_empty", 32'(q_valid), 32'd0);
        evt_in = '0;
        wait_ticks(6);
`endif

        pulse_seen = pulse_total;
        check("final_overflow", 32'(overflow), 32'd0);
        check("final_pulses_nonzero", 32'(pulse_seen > 0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
